sirv_axi_ram_slv: RTL and testbench

- Parametrised AXI3-style slave backed by an internal byte-writable RAM array; successor to the fixed 32/64-bit example AXI peripheral.
- Adds real storage, FIXED/INCR/WRAP bursts, narrow transfers, address decode against a base, and SLVERR/DECERR reporting.
- Independent read and write engines, one outstanding transaction each. Attaches to the SoC's external AXI master port.

---
 rtl/sirv_axi_ram_slv.sv | 275 +++++++++++++++++++++++++++
 tb/tb_sirv_axi_ram_slv.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sirv_axi_ram_slv.sv
// sirv_axi_ram_slv: AXI3-style slave backed by a byte-writable RAM.
// Independent read and write engines, one outstanding transaction each.
// Supports FIXED/INCR/WRAP bursts, narrow beats, base-address decode and
// SLVERR/DECERR reporting.
module sirv_axi_ram_slv #(
    parameter int             AW     = 32,
    parameter int             DW     = 64,
    parameter int             MEM_AW = 12,
    parameter logic [AW-1:0]  BASE   = '0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              axi_arvalid,
    output logic              axi_arready,
    input  logic [AW-1:0]     axi_araddr,
    input  logic [3:0]        axi_arcache,
    input  logic [2:0]        axi_arprot,
    input  logic [1:0]        axi_arlock,
    input  logic [1:0]        axi_arburst,
    input  logic [3:0]        axi_arlen,
    input  logic [2:0]        axi_arsize,

    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [AW-1:0]     axi_awaddr,
    input  logic [3:0]        axi_awcache,
    input  logic [2:0]        axi_awprot,
    input  logic [1:0]        axi_awlock,
    input  logic [1:0]        axi_awburst,
    input  logic [3:0]        axi_awlen,
    input  logic [2:0]        axi_awsize,

    output logic              axi_rvalid,
    input  logic              axi_rready,
    output logic [DW-1:0]     axi_rdata,
    output logic [1:0]        axi_rresp,
    output logic              axi_rlast,

    input  logic              axi_wvalid,
    output logic              axi_wready,
    input  logic [DW-1:0]     axi_wdata,
    input  logic [DW/8-1:0]   axi_wstrb,
    input  logic              axi_wlast,

    output logic              axi_bvalid,
    input  logic              axi_bready,
    output logic [1:0]        axi_bresp
);

    localparam int         STRB     = DW / 8;
    localparam int         LSB      = $clog2(STRB);
    localparam int         DEPTH    = (1 << MEM_AW) / STRB;
    localparam logic [2:0] MAX_SIZE = 3'(LSB);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [DW-1:0] mem [DEPTH];

    r_state_t          r_state;
    logic [MEM_AW-1:0] r_addr;
    logic [3:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [1:0]        r_err;
    logic [3:0]        r_beat;

    w_state_t          w_state;
    logic [MEM_AW-1:0] w_addr;
    logic [3:0]        w_len;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic [1:0]        w_err;
    logic [3:0]        w_beat;
    logic              w_last_bad;

    logic [MEM_AW-1:0] r_next;
    logic [MEM_AW-1:0] w_next;
    logic [1:0]        ar_err;
    logic [1:0]        aw_err;
    logic              mem_we;

    // Cache, protection and lock attributes carry no meaning for a plain RAM.
    logic unused_attr;
    assign unused_attr = ^{axi_arcache, axi_arprot, axi_arlock,
                           axi_awcache, axi_awprot, axi_awlock};

    // Next beat address within the region; INCR wraps modulo the region size.
    function automatic logic [MEM_AW-1:0] next_addr(
        input logic [MEM_AW-1:0] addr,
        input logic [1:0]        burst,
        input logic [3:0]        len,
        input logic [2:0]        size
    );
        logic [MEM_AW-1:0] bytes;
        logic [MEM_AW-1:0] aligned;
        logic [MEM_AW-1:0] incr;
        logic [MEM_AW-1:0] win_mask;
        bytes    = MEM_AW'(1) << size;
        aligned  = addr & ~(bytes - MEM_AW'(1));
        incr     = aligned + bytes;
        win_mask = (bytes * (MEM_AW'(len) + MEM_AW'(1))) - MEM_AW'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (aligned & ~win_mask) | (incr & win_mask);
            default:     next_addr = incr;
        endcase
    endfunction

    // Response code decided once at the address handshake; decode miss wins.
    function automatic logic [1:0] addr_err(
        input logic [AW-1:0] addr,
        input logic [1:0]    burst,
        input logic [3:0]    len,
        input logic [2:0]    size
    );
        if (addr[AW-1:MEM_AW] != BASE[AW-1:MEM_AW])
            addr_err = RESP_DECERR;
        else if (burst == BURST_RSVD || size > MAX_SIZE ||
                 (burst == BURST_WRAP && len != 4'd1 && len != 4'd3 &&
                  len != 4'd7 && len != 4'd15))
            addr_err = RESP_SLVERR;
        else
            addr_err = RESP_OKAY;
    endfunction

    assign r_next = next_addr(r_addr, r_burst, r_len, r_size);
    assign w_next = next_addr(w_addr, w_burst, w_len, w_size);
    assign ar_err = addr_err(axi_araddr, axi_arburst, axi_arlen, axi_arsize);
    assign aw_err = addr_err(axi_awaddr, axi_awburst, axi_awlen, axi_awsize);
    assign mem_we = !rst && (w_state == W_DATA) && axi_wvalid && axi_wready &&
                    (w_err == RESP_OKAY);

    // RAM byte-lane writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB; i++) begin
                if (axi_wstrb[i])
                    mem[w_addr[MEM_AW-1:LSB]][i*8 +: 8] <= axi_wdata[i*8 +: 8];
            end
        end
    end

    // Read engine: registered beats fetched one cycle ahead of presentation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= R_IDLE;
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b0;
            axi_rdata   <= '0;
            axi_rresp   <= RESP_OKAY;
            axi_rlast   <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_err       <= RESP_OKAY;
            r_beat      <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    axi_arready <= 1'b1;
                    if (axi_arvalid && axi_arready) begin
                        axi_arready <= 1'b0;
                        r_addr      <= axi_araddr[MEM_AW-1:0];
                        r_len       <= axi_arlen;
                        r_size      <= axi_arsize;
                        r_burst     <= axi_arburst;
                        r_err       <= ar_err;
                        r_beat      <= '0;
                        axi_rvalid  <= 1'b1;
                        axi_rresp   <= ar_err;
                        axi_rlast   <= (axi_arlen == 4'd0);
                        axi_rdata   <= (ar_err == RESP_OKAY) ?
                                       mem[axi_araddr[MEM_AW-1:LSB]] : '0;
                        r_state     <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi_rvalid && axi_rready) begin
                        if (r_beat == r_len) begin
                            axi_rvalid  <= 1'b0;
                            axi_rlast   <= 1'b0;
                            axi_rdata   <= '0;
                            axi_rresp   <= RESP_OKAY;
                            axi_arready <= 1'b1;
                            r_state     <= R_IDLE;
                        end else begin
                            r_addr    <= r_next;
                            r_beat    <= r_beat + 4'd1;
                            axi_rlast <= ((r_beat + 4'd1) == r_len);
                            axi_rdata <= (r_err == RESP_OKAY) ?
                                         mem[r_next[MEM_AW-1:LSB]] : '0;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write engine: accept address, count beats, then hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state     <= W_IDLE;
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b0;
            axi_bresp   <= RESP_OKAY;
            w_addr      <= '0;
            w_len       <= '0;
            w_size      <= '0;
            w_burst     <= '0;
            w_err       <= RESP_OKAY;
            w_beat      <= '0;
            w_last_bad  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    axi_awready <= 1'b1;
                    if (axi_awvalid && axi_awready) begin
                        axi_awready <= 1'b0;
                        axi_wready  <= 1'b1;
                        w_addr      <= axi_awaddr[MEM_AW-1:0];
                        w_len       <= axi_awlen;
                        w_size      <= axi_awsize;
                        w_burst     <= axi_awburst;
                        w_err       <= aw_err;
                        w_beat      <= '0;
                        w_last_bad  <= 1'b0;
                        w_state     <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi_wvalid && axi_wready) begin
                        w_addr <= w_next;
                        w_beat <= w_beat + 4'd1;
                        if (w_beat == w_len) begin
                            axi_wready <= 1'b0;
                            axi_bvalid <= 1'b1;
                            if (w_err != RESP_OKAY)
                                axi_bresp <= w_err;
                            else if (w_last_bad || !axi_wlast)
                                axi_bresp <= RESP_SLVERR;
                            else
                                axi_bresp <= RESP_OKAY;
                            w_state <= W_RESP;
                        end else if (axi_wlast) begin
                            w_last_bad <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bvalid && axi_bready) begin
                        axi_bvalid  <= 1'b0;
                        axi_bresp   <= RESP_OKAY;
                        axi_awready <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sirv_axi_ram_slv.sv
// Directed testbench for sirv_axi_ram_slv (DW=64, 4 KiB region at 0x8000_0000).
module tb_sirv_axi_ram_slv;

    localparam int          AW     = 32;
    localparam int          DW     = 64;
    localparam int          MEM_AW = 12;
    localparam logic [31:0] BASE   = 32'h8000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            axi_arvalid, axi_arready;
    logic [AW-1:0]   axi_araddr;
    logic [3:0]      axi_arcache;
    logic [2:0]      axi_arprot;
    logic [1:0]      axi_arlock, axi_arburst;
    logic [3:0]      axi_arlen;
    logic [2:0]      axi_arsize;
    logic            axi_awvalid, axi_awready;
    logic [AW-1:0]   axi_awaddr;
    logic [3:0]      axi_awcache;
    logic [2:0]      axi_awprot;
    logic [1:0]      axi_awlock, axi_awburst;
    logic [3:0]      axi_awlen;
    logic [2:0]      axi_awsize;
    logic            axi_rvalid, axi_rready;
    logic [DW-1:0]   axi_rdata;
    logic [1:0]      axi_rresp;
    logic            axi_rlast;
    logic            axi_wvalid, axi_wready;
    logic [DW-1:0]   axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic            axi_wlast;
    logic            axi_bvalid, axi_bready;
    logic [1:0]      axi_bresp;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [63:0] wDataQ [16];
    logic [7:0]  wStrbQ [16];
    logic        wLastQ [16];
    logic [63:0] rDataQ [16];
    logic [1:0]  rRespQ [16];
    logic        rLastQ [16];
    logic [1:0]  bRespGot;

    sirv_axi_ram_slv #(.AW(AW), .DW(DW), .MEM_AW(MEM_AW), .BASE(BASE)) dut (
        .clk(clk), .rst(rst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arlock(axi_arlock),
        .axi_arburst(axi_arburst), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awlock(axi_awlock),
        .axi_awburst(axi_awburst), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Global time limit so a stuck handshake can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic awPhase(input logic [31:0] addr, input logic [1:0] burst,
                           input logic [3:0] len, input logic [2:0] size);
        int guard = 0;
        axi_awaddr  = addr;
        axi_awburst = burst;
        axi_awlen   = len;
        axi_awsize  = size;
        axi_awvalid = 1'b1;
        while (axi_awready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) checkOutput("awready_timeout", axi_awready, 1);
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
    endtask

    task automatic wBeats(input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            int guard = 0;
            axi_wdata  = wDataQ[i];
            axi_wstrb  = wStrbQ[i];
            axi_wlast  = wLastQ[i];
            axi_wvalid = 1'b1;
            while (axi_wready !== 1'b1 && guard < 50) begin
                @(posedge clk); #1; guard++;
            end
            if (guard >= 50) checkOutput("wready_timeout", axi_wready, 1);
            @(posedge clk); #1;
        end
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
    endtask

    task automatic bPhase(output logic [1:0] resp);
        int guard = 0;
        axi_bready = 1'b1;
        while (axi_bvalid !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) checkOutput("bvalid_timeout", axi_bvalid, 1);
        resp = axi_bresp;
        @(posedge clk); #1;
        axi_bready = 1'b0;
    endtask

    task automatic writeBurst(input logic [31:0] addr, input logic [1:0] burst,
                              input logic [3:0] len, input logic [2:0] size);
        awPhase(addr, burst, len, size);
        wBeats(0, int'(len) + 1);
        bPhase(bRespGot);
    endtask

    task automatic arPhase(input logic [31:0] addr, input logic [1:0] burst,
                           input logic [3:0] len, input logic [2:0] size);
        int guard = 0;
        axi_araddr  = addr;
        axi_arburst = burst;
        axi_arlen   = len;
        axi_arsize  = size;
        axi_arvalid = 1'b1;
        while (axi_arready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) checkOutput("arready_timeout", axi_arready, 1);
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
    endtask

    task automatic readBeat(input int i);
        int guard = 0;
        while (axi_rvalid !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) checkOutput("rvalid_timeout", axi_rvalid, 1);
        rDataQ[i] = axi_rdata;
        rRespQ[i] = axi_rresp;
        rLastQ[i] = axi_rlast;
        @(posedge clk); #1;
    endtask

    task automatic readBurst(input logic [31:0] addr, input logic [1:0] burst,
                             input logic [3:0] len, input logic [2:0] size);
        arPhase(addr, burst, len, size);
        axi_rready = 1'b1;
        for (int i = 0; i <= int'(len); i++) readBeat(i);
        axi_rready = 1'b0;
    endtask

    // Linear sequence of directed steps with hand-computed expectations.
    initial begin
        rst = 1'b1;
        axi_arvalid = 0; axi_araddr = 0; axi_arcache = 0; axi_arprot = 0; axi_arlock = 0;
        axi_arburst = 0; axi_arlen = 0; axi_arsize = 0;
        axi_awvalid = 0; axi_awaddr = 0; axi_awcache = 0; axi_awprot = 0; axi_awlock = 0;
        axi_awburst = 0; axi_awlen = 0; axi_awsize = 0;
        axi_rready = 0; axi_wvalid = 0; axi_wdata = 0; axi_wstrb = 0; axi_wlast = 0;
        axi_bready = 0;

        // Reset state: every output low while reset is held.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_arready", axi_arready, 0);
        checkOutput("rst_awready", axi_awready, 0);
        checkOutput("rst_wready",  axi_wready,  0);
        checkOutput("rst_rvalid",  axi_rvalid,  0);
        checkOutput("rst_bvalid",  axi_bvalid,  0);
        checkOutput("rst_rdata",   axi_rdata,   0);
        checkOutput("rst_rlast",   axi_rlast,   0);
        checkOutput("rst_rresp",   axi_rresp,   0);
        checkOutput("rst_bresp",   axi_bresp,   0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_rst_arready", axi_arready, 1);
        checkOutput("post_rst_awready", axi_awready, 1);

        // INCR len=3 write at 0x10, then read it back.
        wDataQ[0] = 64'h1111_1111_1111_1111; wDataQ[1] = 64'h2222_2222_2222_2222;
        wDataQ[2] = 64'h3333_3333_3333_3333; wDataQ[3] = 64'h4444_4444_4444_4444;
        for (int i = 0; i < 4; i++) begin wStrbQ[i] = 8'hFF; wLastQ[i] = (i == 3); end
        writeBurst(BASE + 32'h10, 2'b01, 4'd3, 3'd3);
        checkOutput("incr_bresp", bRespGot, 2'b00);
        readBurst(BASE + 32'h10, 2'b01, 4'd3, 3'd3);
        checkOutput("incr_rdata0", rDataQ[0], 64'h1111_1111_1111_1111);
        checkOutput("incr_rdata1", rDataQ[1], 64'h2222_2222_2222_2222);
        checkOutput("incr_rdata2", rDataQ[2], 64'h3333_3333_3333_3333);
        checkOutput("incr_rdata3", rDataQ[3], 64'h4444_4444_4444_4444);
        checkOutput("incr_rlast0", rLastQ[0], 0);
        checkOutput("incr_rlast2", rLastQ[2], 0);
        checkOutput("incr_rlast3", rLastQ[3], 1);
        checkOutput("incr_rresp3", rRespQ[3], 2'b00);

        // Fill words 0x00/0x08, then WRAP read from 0x18 -> 0x18,0x00,0x08,0x10.
        wDataQ[0] = 64'hAAAA_AAAA_AAAA_AAAA; wDataQ[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        wStrbQ[0] = 8'hFF; wStrbQ[1] = 8'hFF; wLastQ[0] = 1'b0; wLastQ[1] = 1'b1;
        writeBurst(BASE, 2'b01, 4'd1, 3'd3);
        checkOutput("fill_bresp", bRespGot, 2'b00);
        readBurst(BASE + 32'h18, 2'b10, 4'd3, 3'd3);
        checkOutput("wrap_rdata0", rDataQ[0], 64'h2222_2222_2222_2222);
        checkOutput("wrap_rdata1", rDataQ[1], 64'hAAAA_AAAA_AAAA_AAAA);
        checkOutput("wrap_rdata2", rDataQ[2], 64'hBBBB_BBBB_BBBB_BBBB);
        checkOutput("wrap_rdata3", rDataQ[3], 64'h1111_1111_1111_1111);
        checkOutput("wrap_rlast3", rLastQ[3], 1);

        // Narrow byte write to 0x3 lane 3; other lanes keep the 0xAA fill.
        wDataQ[0] = 64'h0000_0000_AB00_0000; wStrbQ[0] = 8'h08; wLastQ[0] = 1'b1;
        writeBurst(BASE + 32'h3, 2'b01, 4'd0, 3'd0);
        checkOutput("narrow_bresp", bRespGot, 2'b00);
        readBurst(BASE, 2'b01, 4'd0, 3'd3);
        checkOutput("narrow_rdata", rDataQ[0], 64'hAAAA_AAAA_ABAA_AAAA);
        checkOutput("narrow_rlast", rLastQ[0], 1);

        // Decode miss: read just past the region returns zeros with DECERR.
        readBurst(BASE + 32'h1000, 2'b01, 4'd2, 3'd3);
        checkOutput("decerr_rdata0", rDataQ[0], 64'h0);
        checkOutput("decerr_rresp0", rRespQ[0], 2'b11);
        checkOutput("decerr_rdata2", rDataQ[2], 64'h0);
        checkOutput("decerr_rresp2", rRespQ[2], 2'b11);
        checkOutput("decerr_rlast1", rLastQ[1], 0);
        checkOutput("decerr_rlast2", rLastQ[2], 1);

        // Reserved burst type: write is swallowed and answered with SLVERR.
        wDataQ[0] = 64'hDEAD_BEEF_DEAD_BEEF; wStrbQ[0] = 8'hFF; wLastQ[0] = 1'b1;
        writeBurst(BASE + 32'h20, 2'b11, 4'd0, 3'd3);
        checkOutput("rsvd_bresp", bRespGot, 2'b10);
        readBurst(BASE + 32'h20, 2'b01, 4'd0, 3'd3);
        checkOutput("rsvd_nowrite", rDataQ[0], 64'h3333_3333_3333_3333);

        // Early wlast: both beats still land, response is SLVERR.
        wDataQ[0] = 64'h5555_5555_5555_5555; wDataQ[1] = 64'h6666_6666_6666_6666;
        wStrbQ[0] = 8'hFF; wStrbQ[1] = 8'hFF; wLastQ[0] = 1'b1; wLastQ[1] = 1'b0;
        writeBurst(BASE + 32'h40, 2'b01, 4'd1, 3'd3);
        checkOutput("wlast_bresp", bRespGot, 2'b10);
        readBurst(BASE + 32'h40, 2'b01, 4'd1, 3'd3);
        checkOutput("wlast_rdata0", rDataQ[0], 64'h5555_5555_5555_5555);
        checkOutput("wlast_rdata1", rDataQ[1], 64'h6666_6666_6666_6666);

        // Back-pressure on the last beat: data and rlast must hold steady.
        arPhase(BASE + 32'h10, 2'b01, 4'd3, 3'd3);
        axi_rready = 1'b1;
        for (int i = 0; i < 3; i++) readBeat(i);
        axi_rready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checkOutput("hold_rvalid", axi_rvalid, 1);
            checkOutput("hold_rdata", axi_rdata, 64'h4444_4444_4444_4444);
            checkOutput("hold_rlast", axi_rlast, 1);
            @(posedge clk); #1;
        end
        axi_rready = 1'b1;
        readBeat(3);
        axi_rready = 1'b0;
        checkOutput("hold_rdata1", rDataQ[1], 64'h2222_2222_2222_2222);
        checkOutput("hold_rdata3", rDataQ[3], 64'h4444_4444_4444_4444);
        checkOutput("hold_after_rvalid", axi_rvalid, 0);

        // Reset in the middle of a 4-beat write after two beats.
        wDataQ[0] = 64'h7777_7777_7777_7777; wDataQ[1] = 64'h8888_8888_8888_8888;
        wStrbQ[0] = 8'hFF; wStrbQ[1] = 8'hFF; wLastQ[0] = 1'b0; wLastQ[1] = 1'b0;
        awPhase(BASE + 32'h80, 2'b01, 4'd3, 3'd3);
        wBeats(0, 2);
        checkOutput("midwr_wready", axi_wready, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_awready", axi_awready, 0);
        checkOutput("midrst_wready",  axi_wready,  0);
        checkOutput("midrst_bvalid",  axi_bvalid,  0);
        checkOutput("midrst_arready", axi_arready, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrst_awready1", axi_awready, 1);
        checkOutput("midrst_bvalid1",  axi_bvalid,  0);
        readBurst(BASE + 32'h80, 2'b01, 4'd1, 3'd3);
        checkOutput("midrst_kept0", rDataQ[0], 64'h7777_7777_7777_7777);
        checkOutput("midrst_kept1", rDataQ[1], 64'h8888_8888_8888_8888);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
